wb_counter_array: RTL

- Parametrised multi-channel successor to the single Wishbone counter on the Caravel user Wishbone port of chip_core.
- Provides NUM_CHANNELS independent up/down counters, each with:
  - a compare register
  - auto-reload
  - sticky match/overflow flags
- Flags are combined into one registered interrupt that drives user_irq_core.
- Slave-only; classic Wishbone single-cycle handshake.

---
 rtl/wb_counter_pkg.sv | 24 ++
 rtl/wb_counter_channel.sv | 77 +++++++
 rtl/wb_counter_array.sv | 70 +++++++
 3 files changed

// File: rtl/wb_counter_pkg.sv
// wb_counter_pkg: register offsets, bit indices, control struct and byte-lane merge for wb_counter_array
package wb_counter_pkg;
  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_COUNT    = 5'h04;
  localparam logic [4:0] OFF_COMPARE  = 5'h08;
  localparam logic [4:0] OFF_STATUS   = 5'h0C;
  localparam logic [4:0] OFF_PRESCALE = 5'h10;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_RELOAD = 1;
  localparam int CTRL_IRQEN  = 2;
  localparam int CTRL_DOWN   = 3;
  localparam int ST_MATCH    = 0;
  localparam int ST_OVF      = 1;
  localparam logic [31:0] CHAN_STRIDE = 32'h20;
  typedef struct packed {
    logic down;
    logic irqen;
    logic reload;
    logic en;
  } ctrl_t;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata, input logic [3:0] sel);
    for (int i = 0; i < 4; i++) merge[8*i+:8] = sel[i] ? wdata[8*i+:8] : old[8*i+:8];
  endfunction
endpackage

// File: rtl/wb_counter_channel.sv
// wb_counter_channel: one up/down counter with compare, auto-reload, sticky flags; prescaler under WB_COUNTER_PRESCALER_EN
module wb_counter_channel
  import wb_counter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_ctrl,
  input  logic             we_count,
  input  logic             we_compare,
  input  logic             we_status,
  input  logic             we_prescale,
  input  logic [31:0]      wdata,
  input  logic [3:0]       sel,
  output ctrl_t            ctrl,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] compare,
  output logic [1:0]       status,
  output logic [7:0]       prescale,
  output logic             irq_req
);
  localparam logic [WIDTH-1:0] ONES = '1;
  logic [31:0] m_ctrl, m_count, m_compare, m_pre;
  logic fire, tick, zero, hit;
  logic [WIDTH-1:0] count_n;
  logic [1:0] set, clr;
  logic unused;
  assign m_ctrl    = merge(32'(ctrl), wdata, sel);
  assign m_count   = merge(32'(count), wdata, sel);
  assign m_compare = merge(32'(compare), wdata, sel);
  assign m_pre     = merge({24'b0, prescale}, wdata, sel);
  assign unused    = ^{m_ctrl, m_count, m_compare, m_pre, we_prescale};
  // a bus write to COUNT replaces the whole tick, flags included
  assign tick    = fire & ~we_count;
  assign zero    = count == '0;
  assign hit     = count == compare;
  assign clr     = (we_status & sel[0]) ? wdata[1:0] : 2'b00;
  assign irq_req = ctrl.irqen & |status;
  always_comb begin
    set = 2'b00;
    set[ST_MATCH] = tick & hit;
    set[ST_OVF] = tick & (ctrl.down ? zero : (count == ONES) & ~hit);
    count_n = ~tick ? count :
              ctrl.down ? (zero ? (ctrl.reload ? compare : ONES) : count - 1'b1) :
              (hit & ctrl.reload) ? '0 : count + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl    <= '0;
      count   <= '0;
      compare <= ONES;
      status  <= '0;
    end else begin
      if (we_ctrl) ctrl <= m_ctrl[CTRL_DOWN:CTRL_EN];
      count <= we_count ? m_count[WIDTH-1:0] : count_n;
      if (we_compare) compare <= m_compare[WIDTH-1:0];
      status <= (status & ~clr) | set;
    end
  end
`ifdef WB_COUNTER_PRESCALER_EN
  logic [7:0] div;
  assign fire = ctrl.en & (div == prescale);
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      div      <= '0;
    end else begin
      if (we_prescale) prescale <= m_pre[7:0];
      div <= (~ctrl.en | we_prescale | fire) ? '0 : div + 1'b1;
    end
  end
`else
  assign fire     = ctrl.en;
  assign prescale = '0;
`endif
endmodule

// File: rtl/wb_counter_array.sv
// wb_counter_array: Wishbone slave with NUM_CHANNELS counters and a registered IRQ; prescaler under WB_COUNTER_PRESCALER_EN
module wb_counter_array
  import wb_counter_pkg::*;
#(
  parameter int          NUM_CHANNELS = 4,
  parameter int          WIDTH        = 32,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o
);
  localparam int SH = $clog2(CHAN_STRIDE);
  logic req, wr;
  logic [2:0] chan;
  logic [4:0] off;
  logic [31:0] rd [8];
  logic [7:0] irq_req;
  assign chan = wb_adr_i[SH+:3];
  assign off  = wb_adr_i[SH-1:0];
  assign req  = wb_cyc_i & wb_stb_i & ~wb_ack_o & (wb_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr   = req & wb_we_i;
  // unpopulated channel slots decode as read-zero, write-ignored
  for (genvar c = 0; c < 8; c++) begin : g_ch
    if (c < NUM_CHANNELS) begin : g_on
      ctrl_t ctrl;
      logic [WIDTH-1:0] count, compare;
      logic [1:0] status;
      logic [7:0] prescale;
      logic hit;
      assign hit = wr & (chan == 3'(c));
      wb_counter_channel #(.WIDTH(WIDTH)) u_ch (
        .clk(wb_clk_i), .rst(wb_rst_i),
        .we_ctrl(hit & (off == OFF_CTRL)), .we_count(hit & (off == OFF_COUNT)),
        .we_compare(hit & (off == OFF_COMPARE)), .we_status(hit & (off == OFF_STATUS)),
        .we_prescale(hit & (off == OFF_PRESCALE)),
        .wdata(wb_dat_i), .sel(wb_sel_i),
        .ctrl(ctrl), .count(count), .compare(compare), .status(status), .prescale(prescale),
        .irq_req(irq_req[c])
      );
      assign rd[c] = off == OFF_CTRL     ? 32'(ctrl) :
                     off == OFF_COUNT    ? 32'(count) :
                     off == OFF_COMPARE  ? 32'(compare) :
                     off == OFF_STATUS   ? {30'b0, status} :
                     off == OFF_PRESCALE ? {24'b0, prescale} : '0;
    end else begin : g_off
      assign rd[c]      = '0;
      assign irq_req[c] = 1'b0;
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      irq_o    <= 1'b0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= (req & ~wb_we_i) ? rd[chan] : '0;
      irq_o    <= |irq_req;
    end
  end
endmodule
